// File: rtl/ct_arb_pkg.sv
// Shared types and the round-robin search used by the ct_field_arb arbiter.
package ct_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int MAX_NI = 16;

    // First asserted request after 'last', wrapping modulo ni; returns 'last' if none.
    function automatic logic [3:0] rr_next(input logic [15:0] req, input int ni, input int last);
        logic [3:0] result;
        logic       found;
        int         idx;
        result = 4'(last);
        found  = 1'b0;
        for (int i = 1; i <= MAX_NI; i++) begin
            idx = last + i;
            if (idx >= ni) idx = idx - ni;
            if (i <= ni && !found && req[idx[3:0]]) begin
                result = idx[3:0];
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ct_rr_pick.sv
// Combinational round-robin picker: request vector and last index -> next index.
module ct_rr_pick
    import ct_arb_pkg::*;
#(
    parameter int NI = 2,
    parameter int WS = 1
) (
    input  logic [NI-1:0] req,
    input  logic [WS-1:0] last,
    output logic [WS-1:0] nxt,
    output logic          any
);

    logic [15:0] req_ext;
    logic [3:0]  pick;

    always_comb begin
        req_ext         = '0;
        req_ext[NI-1:0] = req;
        pick            = rr_next(req_ext, NI, int'(last));
        nxt             = pick[WS-1:0];
        any             = |req;
    end

endmodule

// File: rtl/ct_field_arb.sv
// Packet-locked round-robin arbiter with data/field passthrough.
// Define CT_FIELD_ARB_FASTGRANT_EN to re-arbitrate on the eop beat and skip the idle cycle.
module ct_field_arb
    import ct_arb_pkg::*;
#(
    parameter  int NI = 2,
    parameter  int WD = 8,
    parameter  int WF = 4,
    localparam int WS = ($clog2(NI) > 1) ? $clog2(NI) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NI*WD-1:0] i_data,
    input  logic [NI*WF-1:0] i_field,
    input  logic [NI-1:0]    i_eop,
    input  logic [NI-1:0]    i_valid,
    output logic [NI-1:0]    o_ready,
    output logic [WD-1:0]    o_data,
    output logic [WF-1:0]    o_field,
    output logic             o_eop,
    output logic [WS-1:0]    o_src,
    output logic             o_valid,
    input  logic             i_ready
);

    arb_state_t      state;
    logic [WS-1:0]   gnt;
    logic [WS-1:0]   last;
    logic [WS-1:0]   pick_last;
    logic [WS-1:0]   nxt;
    logic            any;
    logic            done;

    // In BUSY the search starts after the current grant, which only matters for fast grant.
    assign pick_last = (state == BUSY) ? gnt : last;

    ct_rr_pick #(
        .NI (NI),
        .WS (WS)
    ) u_pick (
        .req  (i_valid),
        .last (pick_last),
        .nxt  (nxt),
        .any  (any)
    );

    always_comb begin
        o_data  = i_data[gnt*WD +: WD];
        o_field = i_field[gnt*WF +: WF];
        o_eop   = i_eop[gnt];
        o_valid = (state == BUSY) && i_valid[gnt];
        o_ready = '0;
        if (state == BUSY) o_ready[gnt] = i_ready;
        o_src   = (state == BUSY) ? gnt : last;
        done    = o_valid && i_ready && o_eop;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= WS'(NI - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        gnt   <= nxt;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (done) begin
                        last <= gnt;
`ifdef CT_FIELD_ARB_FASTGRANT_EN
                        if (any) gnt <= nxt;
                        else     state <= IDLE;
`else
                        state <= IDLE;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
